// File: rtl/reward_scan.sv
// Scans the neighbor table for the best next hop and emits a reward/forward packet.
// Optional build macro REWARD_LOWE_FILTER_EN skips low-energy neighbors (threshold E_MIN).
module reward_scan #(
  parameter int WORD_WIDTH = 16,
  parameter int NT_DEPTH   = 32,
  parameter int IDX_W      = 5,
  parameter int TS_W       = 6,
  parameter int E_SHIFT    = 4,
  parameter int H_SHIFT    = 2
`ifdef REWARD_LOWE_FILTER_EN
  , parameter logic [WORD_WIDTH-1:0] E_MIN = 16'h0400
`endif
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic                  iAmDestination,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [TS_W-1:0]       timeslot,
  input  logic [IDX_W:0]        neighborCount,
  output logic [IDX_W-1:0]      nTableIndex,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  input  logic                  okToSend,
  output logic                  rValid,
  output logic [2:0]            rPacketType,
  output logic [WORD_WIDTH-1:0] rSourceID,
  output logic [WORD_WIDTH-1:0] rDestinationID,
  output logic [WORD_WIDTH-1:0] rQValue,
  output logic [WORD_WIDTH-1:0] rEnergyLeft,
  output logic [WORD_WIDTH-1:0] rSourceHops,
  output logic [TS_W-1:0]       rTimeslot,
  output logic                  busy,
  output logic                  noRoute,
  output logic                  reward_done,
  output logic [2:0]            dbg_state_o
);

  // Handshake: rValid rises with all fields stable and holds until a cycle
  // with okToSend=1; the packet is consumed in that cycle and rValid drops next.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    DRAIN   = 3'd2,
    CALC    = 3'd3,
    WAIT_OK = 3'd4
  } state_t;

  localparam int CW = IDX_W + 1;
  localparam int SW = WORD_WIDTH + 4;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  hb_q, hb_d;
  logic [WORD_WIDTH-1:0] src_q, src_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic                  have_q, have_d;
  logic [WORD_WIDTH-1:0] bq_q, bq_d;
  logic [WORD_WIDTH-1:0] bh_q, bh_d;
  logic [WORD_WIDTH-1:0] bid_q, bid_d;

  logic                  rvalid_q, rvalid_d;
  logic [2:0]            rtype_q, rtype_d;
  logic [WORD_WIDTH-1:0] rsrc_q, rsrc_d;
  logic [WORD_WIDTH-1:0] rdst_q, rdst_d;
  logic [WORD_WIDTH-1:0] rqv_q, rqv_d;
  logic [WORD_WIDTH-1:0] ren_q, ren_d;
  logic [WORD_WIDTH-1:0] rhops_q, rhops_d;
  logic [TS_W-1:0]       rts_q, rts_d;
  logic                  noroute_q, noroute_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         nc_clamp;
  logic                  accept;
  logic                  eligible;
  logic                  better;
  logic [SW-1:0]         q_sum;
  logic [WORD_WIDTH-1:0] q_sat;

  assign nc_clamp = (neighborCount > CW'(NT_DEPTH)) ? CW'(NT_DEPTH) : neighborCount;
  assign accept   = (fPacketType == 3'b000) ||
                    ((fPacketType == 3'b011) && iAmDestination);

`ifdef REWARD_LOWE_FILTER_EN
  assign eligible = cmp_vld_q && (mNodeEnergy >= E_MIN);
`else
  logic unused_energy;
  assign unused_energy = ^mNodeEnergy;
  assign eligible = cmp_vld_q;
`endif

  // Strict compares keep the earlier (lower) index on a full tie.
  assign better = eligible &&
                  (!have_q || (mNodeQValue > bq_q) ||
                   ((mNodeQValue == bq_q) && (mNodeHops < bh_q)));

  // Extra headroom so a large hop penalty cannot wrap before the sign test.
  assign q_sum = {4'b0, bq_q}
               + ({4'b0, myEnergy} >> E_SHIFT)
               - ({4'b0, hopsFromSink} << H_SHIFT);

  always_comb begin
    q_sat = q_sum[WORD_WIDTH-1:0];
    if (q_sum[SW-1]) begin
      q_sat = '0;
    end else if (|q_sum[SW-2:WORD_WIDTH]) begin
      q_sat = '1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hb_d      = hb_q;
    src_d     = src_q;
    cmp_vld_d = (state_q == SCAN);
    have_d    = have_q;
    bq_d      = bq_q;
    bh_d      = bh_q;
    bid_d     = bid_q;
    rvalid_d  = rvalid_q;
    rtype_d   = rtype_q;
    rsrc_d    = rsrc_q;
    rdst_d    = rdst_q;
    rqv_d     = rqv_q;
    ren_d     = ren_q;
    rhops_d   = rhops_q;
    rts_d     = rts_q;
    noroute_d = 1'b0;
    done_d    = 1'b0;

    if (better) begin
      have_d = 1'b1;
      bq_d   = mNodeQValue;
      bh_d   = mNodeHops;
      bid_d  = mNodeID;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          if (accept) begin
            hb_d    = (fPacketType == 3'b000);
            src_d   = fSourceID;
            idx_d   = '0;
            cnt_d   = nc_clamp;
            have_d  = 1'b0;
            state_d = (nc_clamp == '0) ? CALC : SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if ({1'b0, idx_q} == cnt_q - CW'(1)) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        state_d = CALC;
      end
      CALC: begin
        if (!have_q) begin
          noroute_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          rvalid_d = 1'b1;
          rtype_d  = hb_q ? 3'b001 : 3'b011;
          rsrc_d   = hb_q ? myNodeID : src_q;
          rdst_d   = bid_q;
          rqv_d    = q_sat;
          ren_d    = myEnergy;
          rhops_d  = hopsFromSink;
          rts_d    = timeslot;
          state_d  = WAIT_OK;
        end
      end
      WAIT_OK: begin
        if (okToSend) begin
          rvalid_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      hb_q      <= 1'b0;
      src_q     <= '0;
      cmp_vld_q <= 1'b0;
      have_q    <= 1'b0;
      bq_q      <= '0;
      bh_q      <= '0;
      bid_q     <= '0;
      rvalid_q  <= 1'b0;
      rtype_q   <= '0;
      rsrc_q    <= '0;
      rdst_q    <= '1;
      rqv_q     <= '0;
      ren_q     <= '0;
      rhops_q   <= '0;
      rts_q     <= '0;
      noroute_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hb_q      <= hb_d;
      src_q     <= src_d;
      cmp_vld_q <= cmp_vld_d;
      have_q    <= have_d;
      bq_q      <= bq_d;
      bh_q      <= bh_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rtype_q   <= rtype_d;
      rsrc_q    <= rsrc_d;
      rdst_q    <= rdst_d;
      rqv_q     <= rqv_d;
      ren_q     <= ren_d;
      rhops_q   <= rhops_d;
      rts_q     <= rts_d;
      noroute_q <= noroute_d;
      done_q    <= done_d;
    end
  end

  assign nTableIndex    = idx_q;
  assign rValid         = rvalid_q;
  assign rPacketType    = rtype_q;
  assign rSourceID      = rsrc_q;
  assign rDestinationID = rdst_q;
  assign rQValue        = rqv_q;
  assign rEnergyLeft    = ren_q;
  assign rSourceHops    = rhops_q;
  assign rTimeslot      = rts_q;
  assign busy           = (state_q != IDLE);
  assign noRoute        = noroute_q;
  assign reward_done    = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_reward_scan.sv
// Directed bench for reward_scan: table model with 1-cycle read latency,
// expected packets queued at request time and compared when rValid rises.
module tb_reward_scan;
  localparam int W  = 16;
  localparam int D  = 32;
  localparam int IW = 5;
  localparam int TW = 6;
  localparam int PW = 3 + 5 * W + TW;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    fPacketType = 3'b000;
  logic          iAmDestination = 1'b0;
  logic [W-1:0]  fSourceID = '0;
  logic [W-1:0]  myNodeID = 16'h0001;
  logic [W-1:0]  myEnergy = 16'h8000;
  logic [W-1:0]  hopsFromSink = 16'h0001;
  logic [TW-1:0] timeslot = 6'd9;
  logic [IW:0]   neighborCount = '0;
  logic [IW-1:0] nTableIndex;
  logic [W-1:0]  mNodeID = '0, mNodeQValue = '0, mNodeHops = '0, mNodeEnergy = '0;
  logic          okToSend = 1'b0;
  logic          rValid;
  logic [2:0]    rPacketType;
  logic [W-1:0]  rSourceID, rDestinationID, rQValue, rEnergyLeft, rSourceHops;
  logic [TW-1:0] rTimeslot;
  logic          busy, noRoute, reward_done;
  logic [2:0]    dbg_state_o;

  logic [W-1:0]  t_id[D], t_q[D], t_h[D], t_e[D];
  logic [PW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mNodeID     <= t_id[nTableIndex];
    mNodeQValue <= t_q[nTableIndex];
    mNodeHops   <= t_h[nTableIndex];
    mNodeEnergy <= t_e[nTableIndex];
  end

  reward_scan dut (
    .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
    .iAmDestination(iAmDestination), .fSourceID(fSourceID),
    .myNodeID(myNodeID), .myEnergy(myEnergy), .hopsFromSink(hopsFromSink),
    .timeslot(timeslot), .neighborCount(neighborCount), .nTableIndex(nTableIndex),
    .mNodeID(mNodeID), .mNodeQValue(mNodeQValue), .mNodeHops(mNodeHops),
    .mNodeEnergy(mNodeEnergy), .okToSend(okToSend), .rValid(rValid),
    .rPacketType(rPacketType), .rSourceID(rSourceID), .rDestinationID(rDestinationID),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rSourceHops(rSourceHops),
    .rTimeslot(rTimeslot), .busy(busy), .noRoute(noRoute), .reward_done(reward_done),
    .dbg_state_o(dbg_state_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] obs_pkt();
    return {rPacketType, rSourceID, rDestinationID, rQValue, rEnergyLeft, rSourceHops, rTimeslot};
  endfunction

  function automatic int model_best(input int nc);
    int cnt = (nc > D) ? D : nc;
    int b = -1;
    for (int i = 0; i < cnt; i++) begin
`ifdef REWARD_LOWE_FILTER_EN
      if (t_e[i] < 16'h0400) continue;
`endif
      if (b < 0 || t_q[i] > t_q[b] || (t_q[i] == t_q[b] && t_h[i] < t_h[b])) b = i;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] model_q(input logic [W-1:0] q);
    int s = int'(q) + int'(myEnergy >> 4) - int'(hopsFromSink) * 4;
    if (s < 0) return '0;
    if (s > 65535) return 16'hFFFF;
    return W'(s);
  endfunction

  // Leaves the bench at the falling edge inside the cycle after en was sampled.
  task automatic pulse_en(input logic [2:0] t, input logic iad, input logic [W-1:0] src,
                          input int nc);
    fPacketType = t; iAmDestination = iad; fSourceID = src;
    neighborCount = (IW+1)'(nc); en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [2:0] t, input logic [W-1:0] src,
                         input int nc, input int hold);
    int b = model_best(nc);
    int lat = 1;
    logic [PW-1:0] pkt;
    if (b < 0) b = 0;
    exp_q.push_back({(t == 3'b000) ? 3'b001 : 3'b011, (t == 3'b000) ? myNodeID : src,
                     t_id[b], model_q(t_q[b]), myEnergy, hopsFromSink, timeslot});
    pulse_en(t, 1'b1, src, nc);
    while (rValid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, ((nc > D) ? D : nc) + 3);
    if (rValid === 1'b1) begin
      pkt = exp_q.pop_front();
      chk({tag, " packet"}, obs_pkt(), pkt);
      for (int i = 0; i < hold; i++) begin
        en = (i == 0);
        @(negedge clk);
        en = 1'b0;
        chk({tag, " hold"}, {rValid, busy, obs_pkt()}, {2'b11, pkt});
      end
    end else begin
      exp_q.delete();
    end
    okToSend = 1'b1;
    @(negedge clk);
    okToSend = 1'b0;
    chk({tag, " grant"}, {rValid, reward_done, busy}, 3'b010);
    @(negedge clk);
    chk({tag, " idle"}, {rValid, reward_done, busy}, 3'b000);
  endtask

  initial begin
    int hi;
    for (int i = 0; i < D; i++) begin
      t_id[i] = W'(i + 5); t_q[i] = '0; t_h[i] = 16'd9; t_e[i] = 16'h1000;
    end
    t_q[0] = 16'h0100; t_q[1] = 16'h0300; t_q[2] = 16'h0300;
    t_h[0] = 16'd2;    t_h[1] = 16'd3;    t_h[2] = 16'd1;

    repeat (3) @(negedge clk);
    chk("reset outputs", {rValid, busy, noRoute, reward_done, nTableIndex, rDestinationID, rQValue},
        {4'b0000, 5'd0, 16'hFFFF, 16'h0000});
    nrst = 1'b1;
    @(negedge clk);

    // Heartbeat, tie on Q broken by hops, held for 10 cycles then granted.
    run_pkt("hb3", 3'b000, 16'h0000, 3, 10);

    // Data not for us is dropped after a one-cycle done pulse.
    pulse_en(3'b011, 1'b0, 16'h000C, 3);
    chk("ignored done", {reward_done, busy, rValid}, 3'b100);
    @(negedge clk);
    chk("ignored quiet", {reward_done, busy, rValid}, 3'b000);

    // Data forward with the grant already present on entry.
    okToSend = 1'b1;
    run_pkt("fwd2", 3'b011, 16'h000C, 2, 0);

    // Empty table: noRoute + done at cycle 2, no packet.
    pulse_en(3'b000, 1'b0, 16'h0000, 0);
    chk("nc0 cycle1", {noRoute, reward_done, busy, rValid}, 4'b0010);
    @(negedge clk);
    chk("nc0 cycle2", {noRoute, reward_done, busy, rValid}, 4'b1100);
    @(negedge clk);
    chk("nc0 after", {noRoute, reward_done, rValid}, 3'b000);

    // Saturation at both ends.
    t_q[0] = 16'h0000; myEnergy = 16'h0000; hopsFromSink = 16'h00FF;
    run_pkt("clamp low", 3'b000, 16'h0000, 1, 0);
    t_q[0] = 16'hFFF0; myEnergy = 16'hFFFF; hopsFromSink = 16'h0000;
    run_pkt("clamp high", 3'b000, 16'h0000, 1, 0);

    // Energy-filter pattern: highest Q sits on a low-energy entry.
    t_q[0] = 16'h0500; t_e[0] = 16'h0100; t_h[0] = 16'd1;
    t_q[1] = 16'h0200; t_e[1] = 16'h0500;
    myEnergy = 16'h2000; hopsFromSink = 16'h0003;
    run_pkt("lowe", 3'b000, 16'h0000, 2, 0);
`ifdef REWARD_LOWE_FILTER_EN
    t_e[1] = 16'h0010;
    pulse_en(3'b000, 1'b0, 16'h0000, 2);
    repeat (3) @(negedge clk);
    chk("lowe none", {noRoute, reward_done, rValid}, 3'b110);
    t_e[1] = 16'h0500;
`endif

    // Random tables with narrow Q range to provoke ties; oversized count clamps to 32.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < D; i++) begin
        t_id[i] = W'($urandom_range(0, 16'hFFFE));
        t_q[i]  = W'($urandom_range(0, 3) * 16'h1000);
        t_h[i]  = W'($urandom_range(0, 3));
        t_e[i]  = W'($urandom_range(0, 16'hFFFF));
      end
      t_e[D-1] = 16'hFFFF;
      myEnergy = W'($urandom_range(0, 16'hFFFF));
      hopsFromSink = W'($urandom_range(0, 16'h0FFF));
      timeslot = TW'($urandom_range(0, 63));
      myNodeID = W'($urandom_range(0, 16'hFFFF));
      run_pkt("rand", (r % 2 == 0) ? 3'b000 : 3'b011, W'($urandom_range(0, 16'hFFFF)),
              (r == 0) ? 40 : ((r == 1) ? D : $urandom_range(1, D)), 1);
    end

    // Reset in the middle of a scan aborts without emitting a packet.
    pulse_en(3'b000, 1'b0, 16'h0000, 5);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("midscan reset", {rValid, busy, noRoute, reward_done, nTableIndex, rDestinationID, rQValue},
        {4'b0000, 5'd0, 16'hFFFF, 16'h0000});
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rValid === 1'b1 || busy === 1'b1) hi++;
    end
    chk("post reset quiet", hi, 0);
    chk("queue empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
